// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronised, prescaled glitch filter and debouncer for slow open-drain lines.
// Defining I2C_LINE_FILTER_GLITCH_CNT_EN adds a saturating rejected-glitch counter (glitch_clr/glitch_cnt).
module i2c_line_filter #(
    parameter int   CHANNELS   = 2,
    parameter int   DIV_W      = 8,
    parameter int   CNT_W      = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DIV_W-1:0]    div,
    input  logic [CNT_W-1:0]    thresh,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
`ifdef I2C_LINE_FILTER_GLITCH_CNT_EN
    ,
    input  logic                glitch_clr,
    output logic [15:0]         glitch_cnt
`endif
);
    localparam logic [CHANNELS-1:0] IDLE = {CHANNELS{IDLE_LEVEL}};
    logic [CHANNELS-1:0] meta, sync, flip;
    logic [DIV_W-1:0]    presc;
    logic [CNT_W-1:0]    eff;
    logic                tick;
    always_ff @(posedge clk or posedge rst)
        if (rst) {meta, sync} <= {IDLE, IDLE};
        else {meta, sync} <= {din, meta};
    // >= rather than == so a live reduction of div never stalls the prescaler
    assign tick = en && presc >= div;
    always_ff @(posedge clk or posedge rst)
        if (rst) presc <= '0;
        else presc <= (!en || tick) ? '0 : presc + 1'b1;
    assign eff = (thresh == '0) ? CNT_W'(1) : thresh;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W:0]   inc;
        logic             d_q, r_q, f_q;
        assign inc     = {1'b0, cnt} + 1'b1;
        assign flip[c] = tick && sync[c] != d_q && inc >= {1'b0, eff};
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                cnt <= '0;
                d_q <= IDLE_LEVEL;
                r_q <= 1'b0;
                f_q <= 1'b0;
            end else begin
                r_q <= flip[c] && sync[c];
                f_q <= flip[c] && !sync[c];
                if (flip[c]) d_q <= sync[c];
                if (!en || flip[c] || (tick && sync[c] == d_q)) cnt <= '0;
                else if (tick) cnt <= inc[CNT_W-1:0];
            end
        assign dout[c] = d_q;
        assign rise[c] = r_q;
        assign fall[c] = f_q;
    end
`ifdef I2C_LINE_FILTER_GLITCH_CNT_EN
    logic [CHANNELS-1:0] reject;
    logic [16:0]         nrej, sum;
    // a reject is a tick that returns a nonzero count to zero while dout holds
    for (genvar c = 0; c < CHANNELS; c++) begin : g_rej
        assign reject[c] = tick && sync[c] == dout[c] && g_ch[c].cnt != '0;
    end
    always_comb begin
        nrej = '0;
        for (int i = 0; i < CHANNELS; i++) nrej = nrej + 17'(reject[i]);
    end
    assign sum = {1'b0, glitch_cnt} + nrej;
    always_ff @(posedge clk or posedge rst)
        if (rst) glitch_cnt <= '0;
        else glitch_cnt <= glitch_clr ? 16'h0 : (sum[16] ? 16'hFFFF : sum[15:0]);
`endif
endmodule

// File: tb/tb_i2c_line_filter.sv
// tb_i2c_line_filter: directed bench with a sample-history model and literal latency checks.
module tb_i2c_line_filter;
    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] div, thresh;
    logic [1:0] din, dout, rise, fall;
`ifdef I2C_LINE_FILTER_GLITCH_CNT_EN
    logic        glitch_clr;
    logic [15:0] glitch_cnt;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    i2c_line_filter dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .thresh(thresh),
        .din(din), .dout(dout), .rise(rise), .fall(fall)
`ifdef I2C_LINE_FILTER_GLITCH_CNT_EN
        , .glitch_clr(glitch_clr), .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the value seen at an edge is din from two edges earlier; on each tick the
    // sample is appended to a history, and dout flips once the last eff samples all differ.
    logic [1:0] m_dout, m_rise, m_fall, d_a, d_b, s;
    int  phase, eff, nrej, run_pre, run_post, m_glitch;
    bit  tk;
    bit  samp [2][$];

    function automatic int trailing(int c);
        int n = 0;
        for (int k = samp[c].size() - 1; k >= 0 && samp[c][k] != m_dout[c]; k--) n++;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dout = 2'b11; m_rise = 2'b00; m_fall = 2'b00;
            d_a = 2'b11; d_b = 2'b11; phase = 0; m_glitch = 0;
            for (int c = 0; c < 2; c++) samp[c].delete();
        end else begin
            s = d_b; d_b = d_a; d_a = din;
            tk = en && phase >= int'(div);
            phase = (!en || tk) ? 0 : phase + 1;
            eff = (thresh == 0) ? 1 : int'(thresh);
            m_rise = 2'b00; m_fall = 2'b00; nrej = 0;
            for (int c = 0; c < 2; c++) begin
                if (!en) samp[c].delete();
                else if (tk) begin
                    run_pre = trailing(c);
                    samp[c].push_back(s[c]);
                    run_post = trailing(c);
                    if (run_post >= eff) begin
                        m_rise[c] = s[c]; m_fall[c] = !s[c]; m_dout[c] = s[c];
                        samp[c].delete();
                    end else if (run_post == 0) begin
                        if (run_pre > 0) nrej++;
                        samp[c].delete();
                    end
                end
            end
`ifdef I2C_LINE_FILTER_GLITCH_CNT_EN
            m_glitch = glitch_clr ? 0 : ((m_glitch + nrej > 65535) ? 65535 : m_glitch + nrej);
`endif
        end
    end

    always @(negedge clk) if (!rst) begin
        check("dout", dout, m_dout);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
`ifdef I2C_LINE_FILTER_GLITCH_CNT_EN
        check("glitch_cnt", glitch_cnt, m_glitch);
`endif
    end

    task automatic step(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic edges_until(int ch, logic val, output int k);
        k = 0;
        while (dout[ch] !== val && k < 50) begin @(posedge clk); #1; k++; end
    endtask

    int k, np;

    initial begin
        rst = 1'b1; en = 1'b1; div = 8'd0; thresh = 8'd4; din = 2'b11;
`ifdef I2C_LINE_FILTER_GLITCH_CNT_EN
        glitch_clr = 1'b0;
`endif
        step(3);
        check("reset_dout", dout, 2'b11);
        check("reset_rise", rise, 2'b00);
        check("reset_fall", fall, 2'b00);
        rst = 1'b0;
        np = 0;
        repeat (20) begin step(1); if (rise != 0 || fall != 0) np++; end
        check("idle_pulses", np, 0);
        // din[1] falls: 2 sync edges + 4 ticks
        din[1] = 1'b0;
        edges_until(1, 1'b0, k);
        check("fall_latency", k, 6);
        check("fall_pulse", fall, 2'b10);
        check("dout0_kept", dout[0], 1'b1);
        step(1);
        check("fall_one_cycle", fall, 2'b00);
        din[1] = 1'b1;
        edges_until(1, 1'b1, k);
        check("rise_latency", k, 6);
        check("rise_pulse", rise, 2'b10);
        step(2);
        // 3-cycle low glitch on din[0] is rejected
`ifdef I2C_LINE_FILTER_GLITCH_CNT_EN
        glitch_clr = 1'b1; step(1); glitch_clr = 1'b0;
        check("glitch_cleared", glitch_cnt, 0);
`endif
        din[0] = 1'b0; step(3); din[0] = 1'b1;
        np = 0;
        repeat (12) begin step(1); if (fall[0]) np++; end
        check("glitch_no_fall", np, 0);
        check("glitch_dout", dout, 2'b11);
`ifdef I2C_LINE_FILTER_GLITCH_CNT_EN
        check("glitch_count", glitch_cnt, 1);
`endif
        // div=3, thresh=2, change aligned just after a tick
        div = 8'd3; thresh = 8'd2; en = 1'b0;
        step(1);
        en = 1'b1;
        step(4);
        din[0] = 1'b0;
        edges_until(0, 1'b0, k);
        check("div3_fall_latency", k, 8);
        check("div3_fall_pulse", fall, 2'b01);
        din[0] = 1'b1;
        edges_until(0, 1'b1, k);
        check("div3_rise_latency", k, 8);
        check("div3_rise_pulse", rise, 2'b01);
        // thresh=0 acts as 1
        div = 8'd0; thresh = 8'd0;
        step(2);
        din[1] = 1'b0;
        edges_until(1, 1'b0, k);
        check("thresh0_latency", k, 3);
        // en=0 freezes outputs
        en = 1'b0;
        np = 0;
        repeat (10) begin din = ~din; step(1); if (rise != 0 || fall != 0) np++; end
        din = 2'b01; step(3);
        check("frozen_pulses", np, 0);
        check("frozen_dout", dout, 2'b01);
        din = 2'b11; en = 1'b1;
        edges_until(1, 1'b1, k);
        check("reenable_latency", k, 3);
        check("reenable_rise", rise, 2'b10);
        // async reset mid-count
        thresh = 8'd4;
        step(3);
        din[0] = 1'b0;
        step(4);
        #2 rst = 1'b1;
        #1 check("async_rst_dout", dout, 2'b11);
        check("async_rst_fall", fall, 2'b00);
        @(posedge clk); #1 rst = 1'b0;
        edges_until(0, 1'b0, k);
        check("post_rst_latency", k, 6);
        check("post_rst_fall", fall, 2'b01);
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end
endmodule
